// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round sequencer and its neighbours.
// The state encoding is shared so surrounding blocks can decode controller phases.
package aes_pkg;

    localparam int NR_AES128       = 10;
    localparam int NR_AES192       = 12;
    localparam int NR_AES256       = 14;
    localparam int KEY_RAM_LATENCY = 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_KEY = 3'd1,
        ST_PRE      = 3'd2,
        ST_INIT     = 3'd3,
        ST_ROUND    = 3'd4,
        ST_FINAL    = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    // A block counts as in progress from the key wait through the final round.
    function automatic logic state_busy(input state_t s);
        logic b;
        case (s)
            ST_WAIT_KEY, ST_PRE, ST_INIT, ST_ROUND, ST_FINAL: b = 1'b1;
            ST_IDLE, ST_DONE:                                 b = 1'b0;
            default:                                          b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Request / round-key / datapath-strobe bundle of the AES round sequencer.
// master drives requests and key readiness; slave is the sequencer itself.
interface aes_round_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              start;
    logic              round_key_rdy;
    logic [ADDR_W-1:0] round_key_addr;
    logic              ld_state;
    logic              round_en;
    logic              final_round;
    logic              busy;
    logic              done;
    logic              abort;

    modport master (
        output start, round_key_rdy,
        input  round_key_addr, ld_state, round_en, final_round, busy, done, abort
    );

    modport slave (
        input  start, round_key_rdy,
        output round_key_addr, ld_state, round_en, final_round, busy, done, abort
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: waits for a valid key schedule, then walks the round-key
// RAM one address ahead of use while strobing load, round and final-round steps.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR     = NR_AES128,
    parameter int ADDR_W = 4
) (
    input logic             Clk,
    input logic             Rst,
    input logic             En,
    aes_round_ctrl_if.slave bus
);

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_LEAD = ADDR_W'(KEY_RAM_LATENCY);
    localparam logic [ADDR_W-1:0] LAST_FULL = ADDR_W'(NR - 1);
    localparam logic [ADDR_W-1:0] LAST_KEY  = ADDR_W'(NR);

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] cnt_r, cnt_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic              ld_r, ld_s;
    logic              rnd_r, rnd_s;
    logic              fin_r, fin_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              abort_r, abort_s;

    // Next-state, counter, address and registered-strobe computation.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        addr_s  = addr_r;
        ld_s    = 1'b0;
        rnd_s   = 1'b0;
        fin_s   = 1'b0;
        done_s  = 1'b0;
        abort_s = 1'b0;
        if (!En) begin
            // Stall: everything holds so the strobes reappear unchanged afterwards.
            ld_s    = ld_r;
            rnd_s   = rnd_r;
            fin_s   = fin_r;
            done_s  = done_r;
            abort_s = abort_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_s  = ADDR_ZERO;
                    addr_s = ADDR_ZERO;
                    if (bus.start) begin
                        state_s = bus.round_key_rdy ? ST_PRE : ST_WAIT_KEY;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_WAIT_KEY: begin
                    if (bus.round_key_rdy) begin
                        state_s = ST_PRE;
                    end else begin
                        state_s = ST_WAIT_KEY;
                    end
                end
                ST_PRE: begin
                    state_s = ST_INIT;
                    cnt_s   = ADDR_ZERO;
                    addr_s  = ADDR_LEAD;
                    ld_s    = 1'b1;
                end
                ST_INIT: begin
                    state_s = ST_ROUND;
                    cnt_s   = ADDR_W'(1);
                    addr_s  = ADDR_W'(1) + ADDR_LEAD;
                    rnd_s   = 1'b1;
                end
                ST_ROUND: begin
                    rnd_s = 1'b1;
                    if (cnt_r == LAST_FULL) begin
                        state_s = ST_FINAL;
                        cnt_s   = LAST_KEY;
                        addr_s  = LAST_KEY;
                        fin_s   = 1'b1;
                    end else begin
                        state_s = ST_ROUND;
                        cnt_s   = cnt_r + ADDR_W'(1);
                        addr_s  = cnt_r + ADDR_W'(1) + ADDR_LEAD;
                    end
                end
                ST_FINAL: begin
                    state_s = ST_DONE;
                    cnt_s   = ADDR_ZERO;
                    addr_s  = ADDR_ZERO;
                    done_s  = 1'b1;
                end
                ST_DONE: begin
                    state_s = ST_IDLE;
                    cnt_s   = ADDR_ZERO;
                    addr_s  = ADDR_ZERO;
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = ADDR_ZERO;
                    addr_s  = ADDR_ZERO;
                end
            endcase

            // Losing the key schedule mid-block cancels it; DONE is already committed.
            if (!bus.round_key_rdy &&
                (state_r inside {ST_PRE, ST_INIT, ST_ROUND, ST_FINAL})) begin
                state_s = ST_WAIT_KEY;
                cnt_s   = ADDR_ZERO;
                addr_s  = ADDR_ZERO;
                ld_s    = 1'b0;
                rnd_s   = 1'b0;
                fin_s   = 1'b0;
                done_s  = 1'b0;
                abort_s = 1'b1;
            end else begin
                abort_s = 1'b0;
            end
        end
        busy_s = state_busy(state_s);
    end

    // State, counter, address and output registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= ADDR_ZERO;
            addr_r  <= ADDR_ZERO;
            ld_r    <= 1'b0;
            rnd_r   <= 1'b0;
            fin_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            abort_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            addr_r  <= addr_s;
            ld_r    <= ld_s;
            rnd_r   <= rnd_s;
            fin_r   <= fin_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            abort_r <= abort_s;
        end
    end

    // Pulses are masked by the enable so a stalled cycle never advances the datapath.
    assign bus.round_key_addr = addr_r;
    assign bus.ld_state       = ld_r & En;
    assign bus.round_en       = rnd_r & En;
    assign bus.final_round    = fin_r & En;
    assign bus.done           = done_r & En;
    assign bus.abort          = abort_r & En;
    assign bus.busy           = busy_r;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed, table-driven bench for aes_round_ctrl (NR=10 instance) plus an NR=14 run.
module tb_aes_round_ctrl;
    import aes_pkg::*;

    logic Clk = 1'b0;
    logic Rst;
    logic En;

    always #5 Clk = ~Clk;

    aes_round_ctrl_if #(.ADDR_W(4)) bus ();
    aes_round_ctrl_if #(.ADDR_W(4)) bus14 ();

    aes_round_ctrl #(.NR(10), .ADDR_W(4)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .En  (En),
        .bus (bus)
    );

    aes_round_ctrl #(.NR(14), .ADDR_W(4)) dut14 (
        .Clk (Clk),
        .Rst (Rst),
        .En  (En),
        .bus (bus14)
    );

    // flag order: {ld_state, round_en, final_round, busy, done, abort}
    logic [5:0] flags10, flags14;
    assign flags10 = {bus.ld_state, bus.round_en, bus.final_round, bus.busy, bus.done, bus.abort};
    assign flags14 = {bus14.ld_state, bus14.round_en, bus14.final_round, bus14.busy, bus14.done, bus14.abort};

    typedef struct {
        logic       start;
        logic       rdy;
        logic       en;
        logic       rst;
        logic [3:0] addr;
        logic [5:0] flags;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic void push(input logic s, input logic r, input logic e,
                                 input logic rs, input int a, input logic [5:0] f);
        vec_t v;
        v.start = s;
        v.rdy   = r;
        v.en    = e;
        v.rst   = rs;
        v.addr  = 4'(a);
        v.flags = f;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int cyc,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Row i: inputs applied during cycle i (sampled at edge i), outputs expected in cycle i.
    task automatic run_table(input string name);
        foreach (vecs[i]) begin
            @(negedge Clk);
            bus.start         = vecs[i].start;
            bus.round_key_rdy = vecs[i].rdy;
            En                = vecs[i].en;
            Rst               = vecs[i].rst;
            #1;
            check({name, ".addr"}, i, 32'(bus.round_key_addr), 32'(vecs[i].addr));
            check({name, ".flags"}, i, 32'(flags10), 32'(vecs[i].flags));
        end
        vecs.delete();
    endtask

    initial begin
        Rst                 = 1'b0;
        En                  = 1'b1;
        bus.start           = 1'b1;
        bus.round_key_rdy   = 1'b1;
        bus14.start         = 1'b0;
        bus14.round_key_rdy = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        #1;
        check("reset.addr", 0, 32'(bus.round_key_addr), 32'd0);
        check("reset.flags", 0, 32'(flags10), 32'd0);
        check("reset14.flags", 0, 32'(flags14), 32'd0);
        @(negedge Clk);
        bus.start = 1'b0;
        Rst       = 1'b1;

        // Nominal block, plus a start in the DONE cycle that must be dropped.
        push(1'b1, 1'b1, 1'b1, 1'b1, 0, 6'b000000);
        push(1'b0, 1'b1, 1'b1, 1'b1, 0, 6'b000100);
        push(1'b0, 1'b1, 1'b1, 1'b1, 1, 6'b100100);
        for (int c = 3; c <= 11; c++) push(1'b0, 1'b1, 1'b1, 1'b1, c - 1, 6'b010100);
        push(1'b0, 1'b1, 1'b1, 1'b1, 10, 6'b011100);
        push(1'b1, 1'b1, 1'b1, 1'b1, 0, 6'b000010);
        push(1'b0, 1'b1, 1'b1, 1'b1, 0, 6'b000000);
        push(1'b0, 1'b1, 1'b1, 1'b1, 0, 6'b000000);
        run_table("nominal");

        // Key schedule not ready until cycle 5.
        push(1'b1, 1'b0, 1'b1, 1'b1, 0, 6'b000000);
        for (int c = 1; c <= 4; c++) push(1'b0, 1'b0, 1'b1, 1'b1, 0, 6'b000100);
        push(1'b0, 1'b1, 1'b1, 1'b1, 0, 6'b000100);
        push(1'b0, 1'b1, 1'b1, 1'b1, 0, 6'b000100);
        push(1'b0, 1'b1, 1'b1, 1'b1, 1, 6'b100100);
        for (int c = 8; c <= 16; c++) push(1'b0, 1'b1, 1'b1, 1'b1, c - 6, 6'b010100);
        push(1'b0, 1'b1, 1'b1, 1'b1, 10, 6'b011100);
        push(1'b0, 1'b1, 1'b1, 1'b1, 0, 6'b000010);
        push(1'b0, 1'b1, 1'b1, 1'b1, 0, 6'b000000);
        run_table("keywait");

        // Enable low for cycles 6..8.
        push(1'b1, 1'b1, 1'b1, 1'b1, 0, 6'b000000);
        push(1'b0, 1'b1, 1'b1, 1'b1, 0, 6'b000100);
        push(1'b0, 1'b1, 1'b1, 1'b1, 1, 6'b100100);
        for (int c = 3; c <= 5; c++) push(1'b0, 1'b1, 1'b1, 1'b1, c - 1, 6'b010100);
        for (int c = 6; c <= 8; c++) push(1'b0, 1'b1, 1'b0, 1'b1, 5, 6'b000100);
        for (int c = 9; c <= 14; c++) push(1'b0, 1'b1, 1'b1, 1'b1, c - 4, 6'b010100);
        push(1'b0, 1'b1, 1'b1, 1'b1, 10, 6'b011100);
        push(1'b0, 1'b1, 1'b1, 1'b1, 0, 6'b000010);
        push(1'b0, 1'b1, 1'b1, 1'b1, 0, 6'b000000);
        run_table("stall");

        // Key loss at cycle 7, recovery at cycle 10; start while waiting is ignored.
        push(1'b1, 1'b1, 1'b1, 1'b1, 0, 6'b000000);
        push(1'b0, 1'b1, 1'b1, 1'b1, 0, 6'b000100);
        push(1'b0, 1'b1, 1'b1, 1'b1, 1, 6'b100100);
        for (int c = 3; c <= 6; c++) push(1'b0, 1'b1, 1'b1, 1'b1, c - 1, 6'b010100);
        push(1'b0, 1'b0, 1'b1, 1'b1, 6, 6'b010100);
        push(1'b0, 1'b0, 1'b1, 1'b1, 0, 6'b000101);
        push(1'b1, 1'b0, 1'b1, 1'b1, 0, 6'b000100);
        push(1'b0, 1'b1, 1'b1, 1'b1, 0, 6'b000100);
        push(1'b0, 1'b1, 1'b1, 1'b1, 0, 6'b000100);
        push(1'b0, 1'b1, 1'b1, 1'b1, 1, 6'b100100);
        for (int c = 13; c <= 21; c++) push(1'b0, 1'b1, 1'b1, 1'b1, c - 11, 6'b010100);
        push(1'b0, 1'b1, 1'b1, 1'b1, 10, 6'b011100);
        push(1'b0, 1'b1, 1'b1, 1'b1, 0, 6'b000010);
        push(1'b0, 1'b1, 1'b1, 1'b1, 0, 6'b000000);
        run_table("abort");

        // Reset (with enable low) during ROUND; start at cycle 5 must be ignored.
        push(1'b1, 1'b1, 1'b1, 1'b1, 0, 6'b000000);
        push(1'b0, 1'b1, 1'b1, 1'b1, 0, 6'b000100);
        push(1'b0, 1'b1, 1'b1, 1'b1, 1, 6'b100100);
        for (int c = 3; c <= 8; c++) push(c == 5, 1'b1, 1'b1, 1'b1, c - 1, 6'b010100);
        push(1'b0, 1'b1, 1'b0, 1'b0, 8, 6'b000100);
        push(1'b0, 1'b1, 1'b1, 1'b1, 0, 6'b000000);
        push(1'b0, 1'b1, 1'b1, 1'b1, 0, 6'b000000);
        run_table("midreset");

        // NR=14 instance: address peaks at 14, final round at 16, done at 17.
        for (int c = 0; c <= 18; c++) begin
            logic [3:0] exp_a;
            logic [5:0] exp_f;
            @(negedge Clk);
            bus14.start = (c == 0);
            #1;
            if (c == 0) begin
                exp_a = 4'd0;  exp_f = 6'b000000;
            end else if (c == 1) begin
                exp_a = 4'd0;  exp_f = 6'b000100;
            end else if (c == 2) begin
                exp_a = 4'd1;  exp_f = 6'b100100;
            end else if (c <= 15) begin
                exp_a = 4'(c - 1); exp_f = 6'b010100;
            end else if (c == 16) begin
                exp_a = 4'd14; exp_f = 6'b011100;
            end else if (c == 17) begin
                exp_a = 4'd0;  exp_f = 6'b000010;
            end else begin
                exp_a = 4'd0;  exp_f = 6'b000000;
            end
            check("nr14.addr", c, 32'(bus14.round_key_addr), 32'(exp_a));
            check("nr14.flags", c, 32'(flags14), 32'(exp_f));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
